// File: rtl/result_ascii_tx_pkg.sv
// Shared constants for the UART result formatter: ASCII bytes, sequencer state
// encoding and the decimal power-of-ten table used by the binary-to-decimal converter.
package result_ascii_tx_pkg;

    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CONV   = 3'd1;
    localparam logic [2:0] ST_SIGN   = 3'd2;
    localparam logic [2:0] ST_DIGITS = 3'd3;
    localparam logic [2:0] ST_EOL    = 3'd4;

    function automatic longint unsigned pow10(input int k);
        longint unsigned p = 64'd1;
        for (int j = 0; j < k; j++) p = p * 64'd10;
        return p;
    endfunction

    // Smallest D with 10^D >= 2^w, i.e. ceil(w*log10(2)).
    function automatic int num_digits(input int w);
        longint unsigned lim = 64'd1 << w;
        longint unsigned p   = 64'd1;
        int d = 0;
        for (int j = 0; j < 20; j++) begin
            if (p < lim) begin
                p = p * 64'd10;
                d++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/result_ascii_tx_bin2dec_seq.sv
// Sequential binary-to-decimal converter: one compare/subtract per cycle against
// constant powers of ten, most significant digit first; digit 0 sits in the low nibble.
module result_ascii_tx_bin2dec_seq
    import result_ascii_tx_pkg::*;
#(
    parameter int W = 12,
    parameter int D = num_digits(W)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W:0]     mag,
    output logic           done,
    output logic [4*D-1:0] digits
);

    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    logic [W:0]    pow_tab [D];
    logic [W:0]    rem;
    logic [IW-1:0] idx;
    logic [3:0]    acc;
    logic          running;

    for (genvar i = 0; i < D; i++) begin : g_pow
        assign pow_tab[i] = (W+1)'(pow10(D - 1 - i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem     <= '0;
            idx     <= '0;
            acc     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            digits  <= '0;
        end else begin
            done <= 1'b0;
            if (start && !running) begin
                rem     <= mag;
                idx     <= '0;
                acc     <= '0;
                running <= 1'b1;
            end else if (running) begin
                if (rem >= pow_tab[idx]) begin
                    rem <= rem - pow_tab[idx];
                    acc <= acc + 4'd1;
                end else begin
                    // Failed compare closes the current digit and moves to the next power.
                    digits[4*idx +: 4] <= acc;
                    acc <= '0;
                    if (idx == LAST) begin
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/result_ascii_tx.sv
// Formats a signed result as a decimal ASCII record ('-' digits EOL) and feeds it
// byte by byte into the UART transmit FIFO, honouring tx_full back-pressure.
//
// state     | meaning
// IDLE      | waiting for start
// CONV      | binary-to-decimal conversion running
// SIGN      | emitting '-' (entered only for negative values)
// DIGITS    | emitting digits, leading zeros suppressed
// EOL       | emitting CR/LF, then one cycle with done_tick before IDLE
module result_ascii_tx
    import result_ascii_tx_pkg::*;
#(
    parameter int W        = 12,
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] value,
    input  logic         tx_full,
    output logic         wr_uart,
    output logic [7:0]   w_data,
    output logic         busy,
    output logic         done_tick
);

    localparam int D  = num_digits(W);
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    logic [2:0]     state;
    logic           sign;
    logic [W:0]     mag;
    logic [W:0]     val_ext;
    logic [W:0]     mag_next;
    logic           conv_start;
    logic           conv_done;
    logic [4*D-1:0] digits;
    logic [IW-1:0]  di;
    logic [3:0]     cur;
    logic           seen_nz;
    logic           cr_sent;
    logic           fin;

    // One extra bit so that -2^(W-1) negates without overflow.
    assign val_ext  = {value[W-1], value};
    assign mag_next = value[W-1] ? (~val_ext + (W+1)'(1)) : val_ext;
    assign cur      = digits[4*di +: 4];
    assign busy     = (state != ST_IDLE);

    result_ascii_tx_bin2dec_seq #(
        .W (W),
        .D (D)
    ) u_bin2dec_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (conv_start),
        .mag    (mag),
        .done   (conv_done),
        .digits (digits)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            sign       <= 1'b0;
            mag        <= '0;
            conv_start <= 1'b0;
            di         <= '0;
            seen_nz    <= 1'b0;
            cr_sent    <= 1'b0;
            fin        <= 1'b0;
            wr_uart    <= 1'b0;
            w_data     <= 8'h00;
            done_tick  <= 1'b0;
        end else begin
            wr_uart    <= 1'b0;
            done_tick  <= 1'b0;
            conv_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign       <= value[W-1];
                        mag        <= mag_next;
                        conv_start <= 1'b1;
                        di         <= '0;
                        seen_nz    <= 1'b0;
                        cr_sent    <= 1'b0;
                        fin        <= 1'b0;
                        state      <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done) state <= sign ? ST_SIGN : ST_DIGITS;
                end
                ST_SIGN: begin
                    if (!tx_full) begin
                        wr_uart <= 1'b1;
                        w_data  <= ASCII_MINUS;
                        state   <= ST_DIGITS;
                    end
                end
                ST_DIGITS: begin
                    // The last digit is always sent so that zero prints as "0".
                    if (!seen_nz && cur == 4'd0 && di != LAST) begin
                        di <= di + IW'(1);
                    end else if (!tx_full) begin
                        wr_uart <= 1'b1;
                        w_data  <= ASCII_ZERO + {4'd0, cur};
                        seen_nz <= 1'b1;
                        if (di == LAST) state <= ST_EOL;
                        else            di    <= di + IW'(1);
                    end
                end
                ST_EOL: begin
                    // fin keeps the block busy through the done_tick cycle.
                    if (fin) begin
                        state <= ST_IDLE;
                    end else if (!tx_full) begin
                        wr_uart <= 1'b1;
                        if (EOL_CRLF && !cr_sent) begin
                            w_data  <= ASCII_CR;
                            cr_sent <= 1'b1;
                        end else begin
                            w_data    <= ASCII_LF;
                            done_tick <= 1'b1;
                            fin       <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
